// File: rtl/deinterleaver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : deinterleaver_pkg
// Brief    : Shared helpers for the row/column block deinterleaver.
// Revision : 1.0 - initial release
// ============================================================================
package deinterleaver_pkg;

    // Counter width for a frame of n bits (at least 1 bit).
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bank address holding output bit n: undoes the TX column-wise read order.
    function automatic int perm_addr(input int n, input int rows, input int cols);
        return (n % cols) * rows + (n / cols);
    endfunction

endpackage
`default_nettype wire

// File: rtl/deint_bank.sv
`default_nettype none
// ============================================================================
// Module   : deint_bank
// Brief    : 1-bit x N storage, one synchronous write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
module deint_bank #(
    parameter int N  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    // Contents are deliberately not reset; the full flags qualify the data.
    logic r_mem [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/deinterleaver.sv
`default_nettype none
// ============================================================================
// Module   : deinterleaver
// Brief    : Ping-pong block deinterleaver; column-wise write, row-wise read.
//            Optional in_sof framing enabled by DEINTERLEAVER_SOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module deinterleaver
    import deinterleaver_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic data_i,
    input  logic in_valid,
    output logic in_ready,
    output logic data_o,
    output logic out_valid,
    input  logic out_ready,
`ifdef DEINTERLEAVER_SOF_EN
    input  logic in_sof,
`endif
    output logic out_sof
);

    localparam int            c_N    = ROWS * COLS;
    localparam int            c_AW   = CNT_W(c_N);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_N - 1);

    logic [c_AW-1:0] r_k;
    logic [c_AW-1:0] r_n;
    logic            r_wsel;
    logic            r_rsel;
    logic [1:0]      r_full;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_store;
    logic            w_set_full;
    logic            w_clr_full;
    logic [c_AW-1:0] w_waddr;
    logic [c_AW-1:0] w_k_next;
    logic [c_AW-1:0] w_raddr;
    logic [1:0]      w_rd;

    assign in_ready   = !r_full[r_wsel];
    assign out_valid  = r_full[r_rsel];
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_clr_full = w_out_fire && (r_n == c_LAST);
    assign w_raddr    = c_AW'(perm_addr(int'(r_n), ROWS, COLS));
    assign data_o     = out_valid && w_rd[r_rsel];
    assign out_sof    = out_valid && (r_n == '0);

`ifdef DEINTERLEAVER_SOF_EN
    logic r_synced;

    // in_sof restarts the frame in place: the partial frame is overwritten, banks stay put.
    always_comb begin
        w_store    = w_in_fire && (r_synced || in_sof);
        w_waddr    = in_sof ? '0 : r_k;
        w_set_full = w_store && !in_sof && (r_k == c_LAST);
        if (in_sof) begin
            w_k_next = c_AW'(1);
        end else if (r_k == c_LAST) begin
            w_k_next = '0;
        end else begin
            w_k_next = r_k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_synced <= 1'b0;
        end else if (w_in_fire && in_sof) begin
            r_synced <= 1'b1;
        end
    end
`else
    always_comb begin
        w_store    = w_in_fire;
        w_waddr    = r_k;
        w_set_full = w_in_fire && (r_k == c_LAST);
        w_k_next   = (r_k == c_LAST) ? '0 : r_k + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= '0;
            r_n    <= '0;
            r_wsel <= 1'b0;
            r_rsel <= 1'b0;
            r_full <= 2'b00;
        end else begin
            if (w_store) begin
                r_k <= w_k_next;
            end
            if (w_out_fire) begin
                r_n <= (r_n == c_LAST) ? '0 : r_n + 1'b1;
            end
            // Set and clear always target different banks, so both may apply together.
            if (w_set_full) begin
                r_full[r_wsel] <= 1'b1;
                r_wsel         <= !r_wsel;
            end
            if (w_clr_full) begin
                r_full[r_rsel] <= 1'b0;
                r_rsel         <= !r_rsel;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            deint_bank #(
                .N  (c_N),
                .AW (c_AW)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_store && (int'(r_wsel) == gi)),
                .i_waddr (w_waddr),
                .i_wdata (data_i),
                .i_raddr (w_raddr),
                .o_rdata (w_rd[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire
